sgd_engine: RTL and testbench
=============================

Name: sgd_engine

Overview:
Clocked, parametrised successor to the fixed 15-feature SGD linear-regression trainer. It streams samples from an external RAM over a request/valid read port and computes the prediction y_cap = w0 + sum(wj*xj) in signed fixed point. It then applies the update wj += (err >>> learn_rate)*xj, with saturation, over a programmable number of epochs. Final weights are exposed through an indexed read port rather than a tristate bus.

Parameters:
LENGTH, 16, width of each signed fixed-point field (y, x, w)
FRAC, 8, fractional bits of every field (Q(LENGTH-FRAC).FRAC)
MAX_FEATURES, 15, number of multiplier lanes / feature slots
ADDR_WIDTH, 12, RAM address width
ACC_GUARD, 4, extra accumulator bits for the y_cap sum
DATA_WIDTH, LENGTH*(MAX_FEATURES+1), RAM word width

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE or DONE
feat  in  4  active feature count, clamped to MAX_FEATURES
data_points  in  ADDR_WIDTH  samples per epoch, at addresses 1..data_points
epoch  in  8  epoch count
learn_rate  in  4  right-shift applied to err
rd_en  out  1  read request, one-cycle pulse
rd_addr  out  ADDR_WIDTH  read address, valid with rd_en
rd_valid  in  1  rd_data valid; arrives 1 or more cycles after rd_en
rd_data  in  DATA_WIDTH  field 0 at the MSBs = y (or w0 at addr 0), then x1..xMAX
w_sel  in  4  weight index for readout
w_out  out  LENGTH  combinational W[w_sel]
err_out  out  LENGTH  last sample error, registered
busy  out  1  high from start acceptance until DONE
done  out  1  high in DONE until the next start

Behaviour:
- Reset (async, RST_N=0): state=IDLE; all W, counters, rd_en, rd_addr, err_out, busy and done = 0. Asserting reset mid-run aborts the run immediately; nothing is retained.
- States: IDLE, LOADW, FETCH, MUL, ACC, UPD, DONE.
- IDLE/DONE + start -> LOADW. Cycle-level actions:
  - Issue rd_en with rd_addr=0; busy=1, done=0.
  - Latch feat, data_points, epoch and learn_rate into shadow registers; later input changes are ignored until the next start.
- LOADW: wait for rd_valid, then W[j] <= field j for j = 0..MAX_FEATURES.
  - If epoch==0 or data_points==0 -> DONE.
  - Otherwise dp=1, ep=0 -> FETCH.
- FETCH: issue rd_en for one cycle with rd_addr=dp. Wait for rd_valid, then latch the sample into the buffer -> MUL.
- MUL (1 cycle): lane j gets A=xj and B=Wj. Lanes j>feat force product 0.
- ACC (1 cycle): y_cap = W0 + sum(products).
  - Sum is taken in LENGTH+ACC_GUARD bits, then saturated to LENGTH.
  - err = sat(y - y_cap); err_out <= err.
- UPD (1 cycle): step = err >>> learn_rate (arithmetic shift).
  - Lanes reused: A=xj, B=step. Products are computed combinationally in the same cycle.
  - W0 <= sat(W0 + step); Wj <= sat(Wj + pj) for j<=feat; Wj for j>feat unchanged.
  - Counter update: if dp==data_points then dp=1, ep+=1; else dp+=1.
  - Then -> DONE if the updated ep==epoch, else FETCH.
- Per-sample latency: read latency + 3 cycles.
- DONE: busy=0, done=1; W is held and readable via w_sel; start restarts from LOADW.
- Multiply rule: the full 2*LENGTH product is shifted >>>FRAC, then saturated to [-2^(LENGTH-1), 2^(LENGTH-1)-1].
- Boundary rules:
  - start while busy is ignored.
  - rd_valid outside LOADW/FETCH is ignored.
  - feat=0 trains the bias only.
  - feat>MAX_FEATURES is clamped.
  - w_sel>MAX_FEATURES returns 0.

Decomposition:
- Package sgd_pkg holds the state encodings and the saturate and fixed-point-multiply functions parametrised on LENGTH/FRAC.
- Sub-module sgd_mul_lane: one signed LENGTH x LENGTH multiply with >>>FRAC and saturation. It is instantiated MAX_FEATURES times and replaces the older bw_mul.

Test Plan:
1. FRAC=8, feat=1, data_points=1, epoch=1, lr=1; addr0 = all zero; addr1: y=0x0100, x1=0x0100 -> err_out=0x0100, W0=0x0080, W1=0x0080, done=1, busy=0.
2. Same sample, epoch=2 -> second pass y_cap=0x0100, err=0x0000 → W0=W1=0x0080 unchanged; exactly 3 rd_en pulses (addr 0,1,1).
3. Saturation: W1 init 0x7F00, x1=0x7F00, y=0x7FFF, lr=0 -> product clamps to 0x7FFF, y_cap=0x7FFF, W values never wrap negative.
4. feat=2 with nonzero x3..x15 and W3..W15=0x0011 -> W3..W15 remain 0x0011; only W0..W2 change.
5. Read latency 1 vs 5 cycles with identical data -> identical final W; busy duration differs by 4 cycles × number of reads.
6. RST_N pulsed low mid-FETCH -> all outputs 0 asynchronously, state IDLE. Then start, epoch=0 -> LOADW then DONE, W equals the addr0 word.

Source files
------------

// File: rtl/sgd_pkg.sv
// Shared state encoding and signed fixed-point helpers for the SGD trainer.
// Latency: combinational helpers only.
// Backpressure: not applicable.
package sgd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_FETCH,
        S_MUL,
        S_ACC,
        S_UPD,
        S_DONE
    } state_t;

    // Clamp a wide signed value into a len-bit two's complement range.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                  input int unsigned len);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (len - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Full-precision product, rescaled by the fractional bits, then clamped.
    function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int unsigned len,
                                                  input int unsigned frac);
        return sat_to((a * b) >>> frac, len);
    endfunction

endpackage

// File: rtl/sgd_mul_lane.sv
// One signed fixed-point multiply lane: (a*b)>>>FRAC saturated to LENGTH bits.
// Latency: combinational.
// Backpressure: none.
module sgd_mul_lane
    import sgd_pkg::*;
#(
    parameter int LENGTH = 16,
    parameter int FRAC   = 8
) (
    input  logic signed [LENGTH-1:0] a,
    input  logic signed [LENGTH-1:0] b,
    output logic signed [LENGTH-1:0] p
);

    assign p = LENGTH'(fx_mul(64'(a), 64'(b), LENGTH, FRAC));

endmodule

// File: rtl/sgd_engine.sv
// Streaming SGD linear-regression trainer over an external sample RAM.
// Latency: per sample, read latency + 3 cycles (MUL, ACC, UPD).
// Backpressure: one read outstanding; FSM stalls in LOADW/FETCH until rd_valid.
module sgd_engine
    import sgd_pkg::*;
#(
    parameter int LENGTH       = 16,
    parameter int FRAC         = 8,
    parameter int MAX_FEATURES = 15,
    parameter int ADDR_WIDTH   = 12,
    parameter int ACC_GUARD    = 4,
    parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [3:0]            feat,
    input  logic [ADDR_WIDTH-1:0] data_points,
    input  logic [7:0]            epoch,
    input  logic [3:0]            learn_rate,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [3:0]            w_sel,
    output logic [LENGTH-1:0]     w_out,
    output logic [LENGTH-1:0]     err_out,
    output logic                  busy,
    output logic                  done
);

    localparam int ACC_W = LENGTH + ACC_GUARD;
    localparam logic [ADDR_WIDTH-1:0] DP_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [3:0]              feat_r;
    logic [3:0]              lr_r;
    logic [ADDR_WIDTH-1:0]   dp_max;
    logic [ADDR_WIDTH-1:0]   dp;
    logic [ADDR_WIDTH-1:0]   dp_n;
    logic [7:0]              ep_max;
    logic [7:0]              ep;
    logic [7:0]              ep_n;

    logic signed [LENGTH-1:0] w      [0:MAX_FEATURES];
    logic signed [LENGTH-1:0] field  [0:MAX_FEATURES];
    logic signed [LENGTH-1:0] xbuf   [1:MAX_FEATURES];
    logic signed [LENGTH-1:0] b_sel  [1:MAX_FEATURES];
    logic signed [LENGTH-1:0] prod   [1:MAX_FEATURES];
    logic signed [LENGTH-1:0] prod_r [1:MAX_FEATURES];
    logic [MAX_FEATURES:1]    lane_en;

    logic signed [LENGTH-1:0] ybuf;
    logic signed [LENGTH-1:0] err_r;
    logic signed [LENGTH-1:0] step;
    logic signed [LENGTH-1:0] y_cap;
    logic signed [LENGTH-1:0] err_c;
    logic signed [ACC_W-1:0]  acc;

    // Field 0 sits at the MSBs of the RAM word.
    for (genvar j = 0; j <= MAX_FEATURES; j++) begin : g_field
        assign field[j] = rd_data[DATA_WIDTH-1-j*LENGTH -: LENGTH];
    end

    // Lanes multiply by the weights in MUL and by the error step in UPD.
    for (genvar j = 1; j <= MAX_FEATURES; j++) begin : g_lane
        assign lane_en[j] = (32'(j) <= 32'(feat_r));
        assign b_sel[j]   = (state == S_UPD) ? step : w[j];
        sgd_mul_lane #(
            .LENGTH (LENGTH),
            .FRAC   (FRAC)
        ) u_lane (
            .a (xbuf[j]),
            .b (b_sel[j]),
            .p (prod[j])
        );
    end

    assign step = err_r >>> lr_r;

    always_comb begin
        acc = ACC_W'(w[0]);
        for (int j = 1; j <= MAX_FEATURES; j++) begin
            acc = acc + ACC_W'(prod_r[j]);
        end
        y_cap = LENGTH'(sat_to(64'(acc), LENGTH));
        err_c = LENGTH'(sat_to(64'(ybuf) - 64'(y_cap), LENGTH));
    end

    always_comb begin
        if (dp == dp_max) begin
            dp_n = DP_ONE;
            ep_n = ep + 8'd1;
        end else begin
            dp_n = dp + DP_ONE;
            ep_n = ep;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            feat_r  <= '0;
            lr_r    <= '0;
            dp_max  <= '0;
            ep_max  <= '0;
            dp      <= '0;
            ep      <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ybuf    <= '0;
            err_r   <= '0;
            for (int j = 0; j <= MAX_FEATURES; j++) w[j] <= '0;
            for (int j = 1; j <= MAX_FEATURES; j++) begin
                xbuf[j]   <= '0;
                prod_r[j] <= '0;
            end
        end else begin
            rd_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        feat_r  <= (32'(feat) > 32'(MAX_FEATURES)) ? 4'(MAX_FEATURES) : feat;
                        lr_r    <= learn_rate;
                        dp_max  <= data_points;
                        ep_max  <= epoch;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state   <= S_LOADW;
                    end
                end
                S_LOADW: begin
                    if (rd_valid) begin
                        for (int j = 0; j <= MAX_FEATURES; j++) w[j] <= field[j];
                        if (ep_max == 8'd0 || dp_max == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            dp      <= DP_ONE;
                            ep      <= '0;
                            rd_en   <= 1'b1;
                            rd_addr <= DP_ONE;
                            state   <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (rd_valid) begin
                        ybuf <= field[0];
                        for (int j = 1; j <= MAX_FEATURES; j++) xbuf[j] <= field[j];
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    for (int j = 1; j <= MAX_FEATURES; j++) begin
                        prod_r[j] <= lane_en[j] ? prod[j] : '0;
                    end
                    state <= S_ACC;
                end
                S_ACC: begin
                    err_r <= err_c;
                    state <= S_UPD;
                end
                S_UPD: begin
                    w[0] <= LENGTH'(sat_to(64'(w[0]) + 64'(step), LENGTH));
                    for (int j = 1; j <= MAX_FEATURES; j++) begin
                        if (lane_en[j]) w[j] <= LENGTH'(sat_to(64'(w[j]) + 64'(prod[j]), LENGTH));
                    end
                    dp <= dp_n;
                    ep <= ep_n;
                    if (ep_n == ep_max) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        rd_en   <= 1'b1;
                        rd_addr <= dp_n;
                        state   <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_out = '0;
        if (32'(w_sel) <= 32'(MAX_FEATURES)) w_out = w[w_sel];
    end

    assign err_out = err_r;

endmodule

// File: tb/tb_sgd_engine.sv
// Directed and randomized bench for sgd_engine against an integer reference model.
module tb_sgd_engine;

    localparam int LENGTH = 16;
    localparam int MAXF   = 15;
    localparam int AW     = 12;
    localparam int DW     = LENGTH * (MAXF + 1);

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            start = 1'b0;
    logic [3:0]      feat = '0;
    logic [AW-1:0]   data_points = '0;
    logic [7:0]      epoch = '0;
    logic [3:0]      learn_rate = '0;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic            rd_valid = 1'b0;
    logic [DW-1:0]   rd_data = '0;
    logic [3:0]      w_sel = '0;
    logic [LENGTH-1:0] w_out;
    logic [LENGTH-1:0] err_out;
    logic            busy;
    logic            done;

    sgd_engine u_dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .feat        (feat),
        .data_points (data_points),
        .epoch       (epoch),
        .learn_rate  (learn_rate),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .w_sel       (w_sel),
        .w_out       (w_out),
        .err_out     (err_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 CLK = ~CLK;

    int mem_f [0:7][0:15];
    int mw [0:15];
    int model_err = 0;
    int lat = 1;
    int rd_cnt = 0;
    int addr_log [0:255];
    int spur_req = 0;
    int spur_done = 0;
    int checks = 0;
    int errors = 0;

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int fmul(input int a, input int b);
        return sat16((a * b) >>> 8);
    endfunction

    function automatic logic [15:0] h16(input int v);
        return v[15:0];
    endfunction

    function automatic logic [DW-1:0] pack(input int a);
        logic [DW-1:0] d;
        int v;
        d = '0;
        for (int j = 0; j <= MAXF; j++) begin
            v = mem_f[a][j];
            d[DW-1-j*LENGTH -: LENGTH] = v[15:0];
        end
        return d;
    endfunction

    // Reference: plain SGD over the samples, epoch by epoch.
    task automatic model_run(input int f, input int dpn, input int epn, input int lr);
        int ycap, err, step, fc;
        fc = (f > MAXF) ? MAXF : f;
        for (int j = 0; j <= MAXF; j++) mw[j] = mem_f[0][j];
        if (epn == 0 || dpn == 0) return;
        for (int e = 0; e < epn; e++) begin
            for (int s = 1; s <= dpn; s++) begin
                ycap = mw[0];
                for (int j = 1; j <= fc; j++) ycap += fmul(mem_f[s][j], mw[j]);
                ycap = sat16(ycap);
                err  = sat16(mem_f[s][0] - ycap);
                step = err >>> lr;
                mw[0] = sat16(mw[0] + step);
                for (int j = 1; j <= fc; j++) mw[j] = sat16(mw[j] + fmul(mem_f[s][j], step));
                model_err = err;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // RAM model: one read at a time, answered lat cycles after rd_en.
    initial begin
        int a;
        forever begin
            if (rd_en) begin
                a = int'(rd_addr);
                addr_log[rd_cnt % 256] = a;
                rd_cnt++;
                repeat (lat - 1) @(negedge CLK);
                rd_data  = pack(a & 7);
                rd_valid = 1'b1;
                @(negedge CLK);
                rd_valid = 1'b0;
            end else if (spur_done != spur_req) begin
                for (int k = 0; k < DW / 32; k++) rd_data[k*32 +: 32] = $urandom;
                rd_valid = 1'b1;
                @(negedge CLK);
                rd_valid = 1'b0;
                spur_done++;
            end else begin
                @(negedge CLK);
            end
        end
    end

    task automatic clear_mem();
        for (int a = 0; a < 8; a++)
            for (int j = 0; j <= MAXF; j++) mem_f[a][j] = 0;
    endtask

    task automatic rand_mem(input int mag);
        for (int a = 0; a < 8; a++)
            for (int j = 0; j <= MAXF; j++)
                mem_f[a][j] = int'($urandom_range(0, 2 * mag)) - mag;
    endtask

    task automatic run_cfg(input int f, input int dpn, input int epn, input int lr,
                           input bit mid_start, output int busy_cyc);
        int c;
        @(negedge CLK);
        feat = 4'(f);
        data_points = AW'(dpn);
        epoch = 8'(epn);
        learn_rate = 4'(lr);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        feat = 4'($urandom);
        data_points = AW'($urandom);
        epoch = 8'($urandom);
        learn_rate = 4'($urandom);
        busy_cyc = 0;
        c = 0;
        while (c < 20000 && !done) begin
            if (busy) busy_cyc++;
            start = (mid_start && c == 3);
            @(negedge CLK);
            c++;
        end
        start = 1'b0;
        chk("run_completes", {31'd0, done}, 32'd1);
        model_run(f, dpn, epn, lr);
    endtask

    task automatic check_result(input string tag);
        for (int s = 0; s <= MAXF; s++) begin
            w_sel = 4'(s);
            #1;
            chk($sformatf("%s_w%0d", tag, s), {16'd0, w_out}, {16'd0, h16(mw[s])});
        end
        chk({tag, "_err"}, {16'd0, err_out}, {16'd0, h16(model_err)});
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        @(negedge CLK);
    endtask

    task automatic wsel_chk(input string tag, input int s, input logic [15:0] exp);
        w_sel = 4'(s);
        #1;
        chk(tag, {16'd0, w_out}, {16'd0, exp});
    endtask

    initial begin
        int bc, b1, b5, base, f, dpn, epn, lr, cnt;

        clear_mem();
        repeat (3) @(negedge CLK);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_rd_addr", {20'd0, rd_addr}, 32'd0);
        chk("rst_err", {16'd0, err_out}, 32'd0);
        wsel_chk("rst_w0", 0, 16'h0000);
        RST_N = 1'b1;
        @(negedge CLK);

        // Single sample, single epoch.
        mem_f[1][0] = 256;
        mem_f[1][1] = 256;
        base = rd_cnt;
        run_cfg(1, 1, 1, 1, 1'b0, bc);
        chk("t1_rd_pulses", 32'(rd_cnt - base), 32'd2);
        chk("t1_err_const", {16'd0, err_out}, 32'h0100);
        wsel_chk("t1_w0_const", 0, 16'h0080);
        wsel_chk("t1_w1_const", 1, 16'h0080);
        check_result("t1");

        // Second epoch converges to zero error.
        base = rd_cnt;
        run_cfg(1, 1, 2, 1, 1'b0, bc);
        chk("t2_rd_pulses", 32'(rd_cnt - base), 32'd3);
        chk("t2_addr0", 32'(addr_log[base % 256]), 32'd0);
        chk("t2_addr1", 32'(addr_log[(base + 1) % 256]), 32'd1);
        chk("t2_addr2", 32'(addr_log[(base + 2) % 256]), 32'd1);
        chk("t2_err_const", {16'd0, err_out}, 32'h0000);
        wsel_chk("t2_w1_const", 1, 16'h0080);
        check_result("t2");

        // Saturation of products, sums and errors.
        clear_mem();
        mem_f[0][1] = 32'h7F00;
        mem_f[1][1] = 32'h7F00;
        mem_f[1][0] = 32'h7FFF;
        run_cfg(1, 1, 1, 0, 1'b0, bc);
        chk("t3_err_const", {16'd0, err_out}, 32'h0000);
        wsel_chk("t3_w1_const", 1, 16'h7F00);
        check_result("t3");
        mem_f[1][0] = -32768;
        run_cfg(1, 1, 2, 0, 1'b0, bc);
        wsel_chk("t3b_w0_const", 0, 16'h8000);
        wsel_chk("t3b_w1_const", 1, 16'hFF00);
        check_result("t3b");

        // Inactive lanes keep their weights; a start while busy is ignored.
        rand_mem(2000);
        for (int j = 3; j <= MAXF; j++) mem_f[0][j] = 32'h11;
        run_cfg(2, 4, 2, 2, 1'b1, bc);
        for (int j = 3; j <= MAXF; j++) wsel_chk($sformatf("t4_w%0d_held", j), j, 16'h0011);
        check_result("t4");

        // Stray rd_valid in DONE must not disturb anything.
        spur_req++;
        repeat (4) @(negedge CLK);
        check_result("spur");

        // Bias-only training.
        rand_mem(1000);
        run_cfg(0, 3, 2, 1, 1'b0, bc);
        check_result("feat0");

        // Read latency only stretches the run.
        rand_mem(32767);
        f  = int'($urandom_range(0, 15));
        lr = int'($urandom_range(0, 15));
        lat = 1;
        run_cfg(f, 3, 2, lr, 1'b0, b1);
        check_result("t5_lat1");
        lat = 5;
        run_cfg(f, 3, 2, lr, 1'b0, b5);
        check_result("t5_lat5");
        chk("t5_busy_delta", 32'(b5 - b1), 32'(4 * (1 + 3 * 2)));

        // Random configurations.
        for (int it = 0; it < 5; it++) begin
            rand_mem((it % 2 == 0) ? 300 : 32767);
            f   = int'($urandom_range(0, 15));
            dpn = int'($urandom_range(1, 7));
            epn = int'($urandom_range(1, 3));
            lr  = int'($urandom_range(0, 15));
            lat = int'($urandom_range(1, 3));
            run_cfg(f, dpn, epn, lr, 1'b0, bc);
            check_result($sformatf("rnd%0d", it));
        end

        // Reset in the middle of a fetch.
        rand_mem(5000);
        lat = 5;
        @(negedge CLK);
        feat = 4'd1;
        data_points = AW'(3);
        epoch = 8'd3;
        learn_rate = 4'd1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        cnt = 0;
        while (cnt < 200 && !(rd_en && rd_addr == AW'(1))) begin
            @(negedge CLK);
            cnt++;
        end
        chk("t6_reached_fetch", {31'd0, rd_en}, 32'd1);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_rd_en", {31'd0, rd_en}, 32'd0);
        chk("t6_rd_addr", {20'd0, rd_addr}, 32'd0);
        chk("t6_err", {16'd0, err_out}, 32'd0);
        wsel_chk("t6_w0", 0, 16'h0000);
        wsel_chk("t6_w1", 1, 16'h0000);
        model_err = 0;
        repeat (10) @(negedge CLK);
        RST_N = 1'b1;
        lat = 1;
        rand_mem(32767);
        run_cfg(3, 2, 0, 1, 1'b0, bc);
        check_result("t6_ep0");
        rand_mem(32767);
        run_cfg(3, 0, 2, 1, 1'b0, bc);
        check_result("t6_dp0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
